float_to_int: RTL and testbench

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/float_to_int_if.sv | 25 ++
 rtl/float_to_int.sv | 155 +++++++++++++++
 tb/tb_float_to_int.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_int_if.sv
// Handshake bundle for the float-to-integer converter: operand in, result out.
interface float_to_int_if #(
  parameter int Width = 32
);
  logic [Width-1:0] DataIn;
  logic             InValid;
  logic             InReady;
  logic [Width-1:0] DataOut;
  logic             OutValid;
  logic             OutReady;
  logic             Overflow;
  logic             Invalid;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output DataIn, InValid, OutReady,
    input  InReady, DataOut, OutValid, Overflow, Invalid
  );

  // Converter side
  modport slave (
    input  DataIn, InValid, OutReady,
    output InReady, DataOut, OutValid, Overflow, Invalid
  );
endinterface

// File: rtl/float_to_int.sv
// Sequential IEEE 754 single-precision to signed integer converter.
// Truncates toward zero. Special values (NaN, infinity, out of range, |x| < 1)
// are resolved at accept time; normal values are aligned with a one-bit-per-cycle
// shifter, so latency is the shift count plus one edge.
module float_to_int #(
  parameter int E     = 8,
  parameter int M     = 23,
  parameter int Width = 32
) (
  input logic           clk,
  input logic           rst,
  float_to_int_if.slave bus
);

  localparam int Bias = (1 << (E - 1)) - 1;

  localparam logic signed [E+1:0] BiasW = Bias[E+1:0];
  localparam logic signed [E+1:0] SatW  = (Width - 1);
  localparam logic signed [E+1:0] MW    = M[E+1:0];
  localparam logic [4:0]          MC    = M[4:0];

  localparam logic [Width-1:0] MaxPos = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [Width-1:0] mag_q;
  logic [4:0]       count_q;
  logic             left_q;
  logic             neg_q;
  logic             ovf_q;
  logic             inv_q;
  logic [Width-1:0] dataOut_q;
  logic             outValid_q;
  logic             overflow_q;
  logic             invalid_q;
  logic             inReady_q;

  logic                 signIn;
  logic [E-1:0]         expIn;
  logic [M-1:0]         manIn;
  logic signed [E+1:0]  ue;
  logic [4:0]           ue5;

  logic [Width-1:0] mag_d;
  logic [4:0]       count_d;
  logic             left_d;
  logic             neg_d;
  logic             ovf_d;
  logic             inv_d;

  assign signIn = bus.DataIn[Width-1];
  assign expIn  = bus.DataIn[Width-2 -: E];
  assign manIn  = bus.DataIn[M-1:0];
  assign ue     = $signed({2'b00, expIn}) - BiasW;
  assign ue5    = ue[4:0];

  // Classify the incoming operand and choose the preset magnitude, shift plan and flags
  always_comb begin
    mag_d   = '0;
    count_d = 5'd0;
    left_d  = 1'b0;
    neg_d   = 1'b0;
    ovf_d   = 1'b0;
    inv_d   = 1'b0;
    if (expIn == '1) begin
      if (manIn != '0) begin
        mag_d = MinNeg;
        inv_d = 1'b1;
      end else begin
        mag_d = signIn ? MinNeg : MaxPos;
        ovf_d = 1'b1;
      end
    end else if (ue[E+1]) begin
      mag_d = '0;
    end else if (ue >= SatW) begin
      mag_d = signIn ? MinNeg : MaxPos;
      // Exactly -2^31 is representable, so it is not an overflow
      ovf_d = !(signIn && (ue == SatW) && (manIn == '0));
    end else begin
      mag_d = {{(Width-M-1){1'b0}}, 1'b1, manIn};
      neg_d = signIn;
      if (ue < MW) begin
        left_d  = 1'b0;
        count_d = MC - ue5;
      end else begin
        left_d  = 1'b1;
        count_d = ue5 - MC;
      end
    end
  end

  // Control FSM with shifter datapath and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      count_q    <= 5'd0;
      left_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      dataOut_q  <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.InValid) begin
            mag_q     <= mag_d;
            count_q   <= count_d;
            left_q    <= left_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            inv_q     <= inv_d;
            inReady_q <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q != 5'd0) begin
            mag_q   <= left_q ? (mag_q << 1) : (mag_q >> 1);
            count_q <= count_q - 5'd1;
          end else begin
            dataOut_q  <= neg_q ? -mag_q : mag_q;
            overflow_q <= ovf_q;
            invalid_q  <= inv_q;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.InReady  = inReady_q;
  assign bus.DataOut  = dataOut_q;
  assign bus.OutValid = outValid_q;
  assign bus.Overflow = overflow_q;
  assign bus.Invalid  = invalid_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed testbench for float_to_int: reset, normal conversions, special
// values, backpressure, back-to-back throughput and reset mid-conversion.
module tb_float_to_int;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  float_to_int_if #(.Width(32)) bus ();

  float_to_int #(.E(8), .M(23), .Width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] din;
    logic [31:0] dout;
    logic        ov;
    logic        inv;
    logic [5:0]  lat;
  } vec_t;

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Present one operand, measure latency in edges, capture the result, then hand it off
  task automatic doConvert(input logic [31:0] din, output logic [31:0] dout,
                           output logic ov, output logic inv, output int lat);
    bus.DataIn  = din;
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    bus.DataIn  = $urandom;
    lat = 0;
    while (!bus.OutValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = bus.DataOut;
    ov   = bus.Overflow;
    inv  = bus.Invalid;
    if (bus.OutValid) begin
      bus.OutReady = 1'b1;
      @(posedge clk); #1;
      bus.OutReady = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++; if (bus.InReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_inready: got %b, expected 1", bus.InReady); end
    checks++; if (bus.OutValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_outvalid: got %b, expected 0", bus.OutValid); end
    checks++; if (bus.DataOut !== 32'h0) begin fails++; $display("[TB] FAIL reset_dataout: got %h, expected 00000000", bus.DataOut); end
    checks++; if (bus.Overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b, expected 0", bus.Overflow); end
    checks++; if (bus.Invalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_invalid: got %b, expected 0", bus.Invalid); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.InReady !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_inready: got %b, expected 1", bus.InReady); end
  endtask

  task automatic runTable(input string tag, input vec_t tbl [], input int n);
    logic [31:0] dout;
    logic        ov;
    logic        inv;
    int          lat;
    for (int i = 0; i < n; i++) begin
      doConvert(tbl[i].din, dout, ov, inv, lat);
      checks++; if (dout !== tbl[i].dout) begin fails++; $display("[TB] FAIL %s_data[%h]: got %h, expected %h", tag, tbl[i].din, dout, tbl[i].dout); end
      checks++; if (ov !== tbl[i].ov) begin fails++; $display("[TB] FAIL %s_overflow[%h]: got %b, expected %b", tag, tbl[i].din, ov, tbl[i].ov); end
      checks++; if (inv !== tbl[i].inv) begin fails++; $display("[TB] FAIL %s_invalid[%h]: got %b, expected %b", tag, tbl[i].din, inv, tbl[i].inv); end
      checks++; if (lat !== int'(tbl[i].lat)) begin fails++; $display("[TB] FAIL %s_latency[%h]: got %0d, expected %0d", tag, tbl[i].din, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_normal;
    vec_t tbl [];
    tbl = new[8];
    tbl[0] = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 6'd24};
    tbl[1] = '{32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b0, 6'd18};
    tbl[2] = '{32'hC0400000, 32'hFFFFFFFD, 1'b0, 1'b0, 6'd23};
    tbl[3] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 6'd8};
    tbl[4] = '{32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b0, 6'd24};
    tbl[5] = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 6'd1};
    tbl[6] = '{32'h41200000, 32'h0000000A, 1'b0, 1'b0, 6'd21};
    tbl[7] = '{32'hC1A40000, 32'hFFFFFFEC, 1'b0, 1'b0, 6'd20};
    runTable("normal", tbl, 8);
  endtask

  task automatic test_special;
    vec_t tbl [];
    tbl = new[12];
    tbl[0]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 6'd1};
    tbl[1]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 6'd1};
    tbl[2]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 6'd1};
    tbl[3]  = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 6'd1};
    tbl[4]  = '{32'h7FC00000, 32'h80000000, 1'b0, 1'b1, 6'd1};
    tbl[5]  = '{32'hFFC00001, 32'h80000000, 1'b0, 1'b1, 6'd1};
    tbl[6]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b0, 6'd1};
    tbl[7]  = '{32'h80000001, 32'h00000000, 1'b0, 1'b0, 6'd1};
    tbl[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 6'd1};
    tbl[9]  = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 6'd1};
    tbl[10] = '{32'h5F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 6'd1};
    tbl[11] = '{32'hBF7FFFFF, 32'h00000000, 1'b0, 1'b0, 6'd1};
    runTable("special", tbl, 12);
  endtask

  task automatic test_backpressure;
    int lat;
    int xfers;
    bus.DataIn   = 32'h4B000001;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.OutValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL bp_latency: got %0d, expected 1", lat); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (bus.DataOut !== 32'h00800001) begin fails++; $display("[TB] FAIL bp_data_cycle%0d: got %h, expected 00800001", c, bus.DataOut); end
      checks++; if (bus.OutValid !== 1'b1) begin fails++; $display("[TB] FAIL bp_outvalid_cycle%0d: got %b, expected 1", c, bus.OutValid); end
      checks++; if (bus.InReady !== 1'b0) begin fails++; $display("[TB] FAIL bp_inready_cycle%0d: got %b, expected 0", c, bus.InReady); end
      @(posedge clk); #1;
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    xfers = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.OutValid && bus.OutReady) xfers++;
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b0;
    checks++; if (xfers !== 1) begin fails++; $display("[TB] FAIL bp_transfers: got %0d, expected 1", xfers); end
    checks++; if (bus.InReady !== 1'b1) begin fails++; $display("[TB] FAIL bp_idle_after: got %b, expected 1", bus.InReady); end
  endtask

  task automatic test_back_to_back;
    int acc [$];
    int xfers;
    int guard;
    bus.DataIn   = 32'h4B800001;
    bus.InValid  = 1'b1;
    bus.OutReady = 1'b1;
    xfers = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.InValid && bus.InReady) acc.push_back(c);
      if (bus.OutValid && bus.OutReady) begin
        xfers++;
        checks++; if (bus.DataOut !== 32'h01000002) begin fails++; $display("[TB] FAIL b2b_data_cycle%0d: got %h, expected 01000002", c, bus.DataOut); end
      end
      @(posedge clk); #1;
    end
    bus.InValid = 1'b0;
    checks++; if (acc.size() !== 5) begin fails++; $display("[TB] FAIL b2b_accepts: got %0d, expected 5", acc.size()); end
    checks++; if (xfers !== 5) begin fails++; $display("[TB] FAIL b2b_transfers: got %0d, expected 5", xfers); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] !== 4) begin fails++; $display("[TB] FAIL b2b_gap%0d: got %0d, expected 4", i, acc[i] - acc[i-1]); end
    end
    guard = 0;
    while (!(bus.InReady && !bus.OutValid) && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.OutReady = 1'b0;
    checks++; if (guard >= 10) begin fails++; $display("[TB] FAIL b2b_drain: got stuck, expected return to idle"); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] dout;
    logic        ov;
    logic        inv;
    int          lat;
    bus.DataIn  = 32'h3F800000;
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    repeat (4) @(posedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.OutValid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_outvalid: got %b, expected 0", bus.OutValid); end
    checks++; if (bus.InReady !== 1'b1) begin fails++; $display("[TB] FAIL midrst_inready: got %b, expected 1", bus.InReady); end
    checks++; if (bus.DataOut !== 32'h0) begin fails++; $display("[TB] FAIL midrst_dataout: got %h, expected 00000000", bus.DataOut); end
    @(posedge clk); #1;
    rst = 1'b0;
    doConvert(32'h40400000, dout, ov, inv, lat);
    checks++; if (dout !== 32'h00000003) begin fails++; $display("[TB] FAIL midrst_data: got %h, expected 00000003", dout); end
    checks++; if ({ov, inv} !== 2'b00) begin fails++; $display("[TB] FAIL midrst_flags: got %b, expected 00", {ov, inv}); end
    checks++; if (lat !== 23) begin fails++; $display("[TB] FAIL midrst_latency: got %0d, expected 23", lat); end
  endtask

  // Test sequence
  initial begin
    checks       = 0;
    fails        = 0;
    rst          = 1'b1;
    bus.DataIn   = 32'h0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
